// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg : loader FSM states, stream framing, status flag type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } loader_state_e;

  localparam int HDR_LEN_BYTES  = 2;
  localparam int CSUM_LEN_BYTES = 1;

  typedef struct packed {
    logic done;
    logic error;
  } control_types_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_packer.sv
// ---------------------------------------------------------------------------
// byte_to_word_packer : gathers four bytes little-endian into one 32-bit word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;

  // Earlier bytes shift down, so the fourth byte lands directly in bits 31:24.
  assign word_ready_o = push_i && (byte_idx_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
    end else if (clear_i) begin
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
    end else if (push_i) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      shift_q    <= {byte_i, shift_q[23:8]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader : streams a length/payload/checksum image into instruction memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

  loader_state_e    state_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [IDX_W-1:0] word_idx_d;
  logic [15:0]      len_q;
  logic [15:0]      len_d;
  logic [7:0]       csum_q;
  logic             wr_en_q;
  logic [31:0]      addr_q;
  logic [31:0]      wr_data_q;
  logic             cpu_resetn_q;
  control_types_t   status_q;

  logic             in_session;
  logic             xfer;
  logic             session_start;
  logic             word_ready;
  logic [31:0]      packed_word;

  assign in_session    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                         (state_q == S_DATA)   || (state_q == S_CHECK);
  // The write-strobe cycle stalls the stream so the word index can advance.
  assign byte_ready    = in_session && !wr_en_q;
  assign xfer          = byte_valid && byte_ready;
  assign session_start = start && !in_session;
  assign word_idx_d    = word_idx_q + IDX_W'(1);
  assign len_d         = {byte_data, len_q[7:0]};

  assign busy          = in_session;
  assign done          = status_q.done;
  assign error         = status_q.error;
  assign imem_wr_en    = wr_en_q;
  assign imem_addr     = addr_q;
  assign imem_wr_data  = wr_data_q;
  assign cpu_resetn    = cpu_resetn_q;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (session_start),
    .push_i       (xfer && (state_q == S_DATA)),
    .byte_i       (byte_data),
    .word_ready_o (word_ready),
    .word_o       (packed_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      len_q        <= 16'd0;
      csum_q       <= 8'd0;
      wr_en_q      <= 1'b0;
      addr_q       <= 32'd0;
      wr_data_q    <= 32'd0;
      cpu_resetn_q <= 1'b0;
      status_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q      <= S_LEN_LO;
            word_idx_q   <= '0;
            csum_q       <= 8'd0;
            status_q     <= '0;
            cpu_resetn_q <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= byte_data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= byte_data;
            if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else if (int'(len_d) > DEPTH_WORDS) begin
              state_q        <= S_ERROR;
              status_q.error <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (wr_en_q) begin
            word_idx_q <= word_idx_d;
            if (32'(word_idx_d) == 32'(len_q)) begin
              state_q <= S_CHECK;
            end
          end else if (xfer) begin
            csum_q <= csum_q ^ byte_data;
            if (word_ready) begin
              wr_en_q   <= 1'b1;
              addr_q    <= 32'({word_idx_q, 2'b00});
              wr_data_q <= packed_word;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (byte_data == csum_q) begin
              state_q       <= S_DONE;
              status_q.done <= 1'b1;
              cpu_resetn_q  <= 1'b1;
            end else begin
              state_q        <= S_ERROR;
              status_q.error <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader : scoreboard bench for program_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;
  import program_loader_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imem_wr_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_wr_data;
  logic        cpu_resetn;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_resetn   (cpu_resetn),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  logic [7:0]  run_csum;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (imem_wr_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wr_data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   imem_addr, imem_wr_data, e.addr, e.data);
        end
      end
      n_tests++;
      if (byte_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_during_write: got %b, expected 0", byte_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  guard = 0;
    bit  sent  = 1'b0;
    while (!sent) begin
      @(negedge clk);
      if (rnd && ($urandom_range(1, 0) == 0)) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        sent       = byte_ready;
      end
      guard++;
      if (guard > 200) begin
        n_fail++;
        $display("FAIL byte_timeout: byte_ready stuck at %b, expected 1", byte_ready);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({busy, byte_ready, done, error, cpu_resetn} !== 5'b11000) begin
      n_fail++;
      $display("FAIL start: got busy/ready/done/err/cpurn=%b, expected 11000",
               {busy, byte_ready, done, error, cpu_resetn});
    end
    run_csum = 8'd0;
  endtask

  task automatic send_header(input logic [15:0] len, input bit rnd);
    logic [15:0] l;
    l = len;
    for (int i = 0; i < HDR_LEN_BYTES; i++) send_byte(l[8*i +: 8], rnd);
  endtask

  task automatic send_payload(input int first, input int last, input bit rnd);
    logic [31:0] w;
    for (int i = first; i <= last; i++) begin
      w = words[i];
      exp_q.push_back('{addr: 32'(i * 4), data: w});
      for (int b = 0; b < 4; b++) begin
        run_csum ^= w[8*b +: 8];
        send_byte(w[8*b +: 8], rnd);
      end
    end
  endtask

  task automatic wait_end();
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1 || error === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic check_finish(input string name, input logic want_done);
    wait_end();
    n_tests++;
    if ({done, error, cpu_resetn, busy, byte_ready} !== {want_done, !want_done, want_done, 2'b00}) begin
      n_fail++;
      $display("FAIL %s: got done/err/cpurn/busy/ready=%b, expected %b", name,
               {done, error, cpu_resetn, busy, byte_ready}, {want_done, !want_done, want_done, 2'b00});
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d pending writes, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_resetn, busy, done, error} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b wr=%b addr=%h data=%h cpurn=%b busy=%b done=%b err=%b, expected all 0",
               byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_resetn, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    words = '{32'h0000_0513, 32'h0010_05B3};
    pulse_start();
    send_header(16'd2, 1'b0);
    send_payload(0, 1, 1'b0);
    send_byte(run_csum, 1'b0);
    check_finish("basic", 1'b1);
  endtask

  task automatic test_bad_csum();
    words = '{32'h0010_0093};
    pulse_start();
    send_header(16'd1, 1'b0);
    send_payload(0, 0, 1'b0);
    n_tests++;
    if (run_csum !== 8'h83) begin
      n_fail++;
      $display("FAIL model_csum: got %h, expected 83", run_csum);
    end
    send_byte(8'h00, 1'b0);
    check_finish("bad_csum", 1'b0);
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_header(16'd0, 1'b0);
    send_byte(8'h00, 1'b0);
    check_finish("zero_len", 1'b1);
  endtask

  task automatic test_too_long();
    pulse_start();
    send_header(16'h0101, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({error, done, byte_ready, busy, cpu_resetn} !== 5'b10000) begin
      n_fail++;
      $display("FAIL too_long: got err/done/ready/busy/cpurn=%b, expected 10000",
               {error, done, byte_ready, busy, cpu_resetn});
    end
  endtask

  task automatic test_random_valid();
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    pulse_start();
    send_header(16'd4, 1'b1);
    send_payload(0, 1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if ({busy, done, error} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_ignored: got busy/done/err=%b, expected 100", {busy, done, error});
    end
    send_payload(2, 3, 1'b1);
    send_byte(run_csum, 1'b1);
    check_finish("random_valid", 1'b1);
  endtask

  task automatic test_reset_mid();
    words = '{32'hA1B2_C3D4};
    pulse_start();
    send_header(16'd3, 1'b0);
    send_payload(0, 0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_resetn, busy, done, error} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ready=%b wr=%b addr=%h data=%h cpurn=%b busy=%b done=%b err=%b, expected all 0",
               byte_ready, imem_wr_en, imem_addr, imem_wr_data, cpu_resetn, busy, done, error);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_writes: got %0d pending writes, expected 0", exp_q.size());
    end
    @(negedge clk);
    reset = 1'b0;
    words = '{32'h0000_006F};
    pulse_start();
    send_header(16'd1, 1'b0);
    send_payload(0, 0, 1'b0);
    send_byte(run_csum, 1'b0);
    check_finish("after_reset", 1'b1);
  endtask

  task automatic test_full_depth();
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    pulse_start();
    send_header(16'(DEPTH), 1'b0);
    send_payload(0, DEPTH - 1, 1'b0);
    send_byte(run_csum, 1'b0);
    check_finish("full_depth", 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_zero_len();
    test_too_long();
    test_random_valid();
    test_reset_mid();
    test_full_depth();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
